inst_fetch_unit: RTL

//   Fetch stage feeding the instruction decoder. Holds the PC and issues one read at a

---
 rtl/inst_fetch_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: holds the PC and issues one instruction-memory read at a time.
// It captures the returned word in the instruction register and presents it to the decoder
// with a valid/ready handshake. Branch redirects squash in-flight work, and halt stops
// fetching after the current instruction has been delivered.
module inst_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
    parameter int                PC_STEP  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [31:0]       ir_data,
    output logic [ADDR_W-1:0] ir_pc,
    output logic [5:0]        opcode,
    output logic [5:0]        func,
    output logic              halted
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_FULL   = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              drop_q, drop_d;
    logic [31:0]       ir_data_q, ir_data_d;
    logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;

    // State, PC, drop flag and instruction register storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            drop_q    <= 1'b0;
            ir_data_q <= 32'h0000_0000;
            ir_pc_q   <= {ADDR_W{1'b0}};
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            drop_q    <= drop_d;
            ir_data_q <= ir_data_d;
            ir_pc_q   <= ir_pc_d;
        end
    end

    // Next-state logic; a redirect outranks every other event in busy states.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drop_d    = drop_q;
        ir_data_d = ir_data_q;
        ir_pc_d   = ir_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (halt) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (imem_req_ready) begin
                        // Request already went out for the old PC: its word must be dropped.
                        drop_d  = 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else if (imem_req_ready) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (imem_rsp_valid) begin
                        drop_d  = 1'b0;
                        state_d = ST_FETCH;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = ST_WAIT;
                    end
                end else if (imem_rsp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = ST_FETCH;
                    end else begin
                        ir_data_d = imem_rsp_data;
                        ir_pc_d   = pc_q;
                        pc_d      = pc_q + ADDR_W'(PC_STEP);
                        state_d   = ST_FULL;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_FULL: begin
                if (redirect_valid) begin
                    // Squash the held instruction even if the decoder is ready.
                    pc_d    = redirect_pc;
                    state_d = ST_FETCH;
                end else if (ir_ready) begin
                    if (halt) begin
                        state_d = ST_HALTED;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_FULL;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
                drop_d  = 1'b0;
            end
        endcase
    end

    // Outputs decode only from registered state, so no input reaches an output combinationally.
    assign imem_req_valid = (state_q == ST_FETCH);
    assign imem_addr      = pc_q;
    assign ir_valid       = (state_q == ST_FULL);
    assign halted         = (state_q == ST_HALTED);
    assign ir_data        = ir_data_q;
    assign ir_pc          = ir_pc_q;
    assign opcode         = ir_data_q[31:26];
    assign func           = ir_data_q[5:0];

endmodule
